attack_gauge: RTL and testbench
===============================

ATTACK_GAUGE -- requirements
Module: attack_gauge

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all registers update on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset; asserted low forces all registers to reset values immediately.
REQ-003 SHALL have tick, input, 1, gauge-advance enable, one clk cycle wide, about 10 Hz.
REQ-004 SHALL have atk_start, input, 1, level, requests an attack round.
REQ-005 SHALL have atk_button, input, 1, raw player strike button, level.
REQ-006 SHALL have atk_reset, input, 1, synchronous restart, returns block to IDLE.
REQ-007 SHALL have dmg_mon, output, 8, damage dealt to the monster, unsigned.
REQ-008 SHALL have atk_gage, output, 8, current gauge position, 0..100.
REQ-009 SHALL have atk_pass, output, 1, high while a round result is valid.
REQ-010 SHALL have atk_state, output, 2, current state: IDLE=0, RUN=1, DONE=2; 3 unused.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE; unused encoding 3 SHALL go to IDLE on the next clk.
REQ-012 IDLE: atk_start=1 SHALL enter RUN on the next clk with atk_gage=0; atk_start SHALL be ignored in RUN and DONE.
REQ-013 RUN: on a clk with tick=1 and atk_gage<100, atk_gage SHALL increment by 1; with tick=0 it SHALL hold.
REQ-014 RUN: on a clk with tick=1 and atk_gage==100 and no strike, the block SHALL enter DONE with dmg_mon=0 (miss); atk_gage SHALL hold at 100.
REQ-015 Strike SHALL be a rising edge of atk_button: atk_button=1 and its registered previous value=0, sampled every clk, independent of tick.
REQ-016 The button-previous register SHALL update every clk in all states; a button held high across entry to RUN SHALL NOT count as a strike.
REQ-017 RUN: on a strike clk, the block SHALL capture the current registered atk_gage value (G) and enter DONE on that same edge.
REQ-018 On that edge, dmg_mon SHALL load D = 40 - |G - 50| if |G - 50| < 40, else 0; range 0..40.
REQ-019 If a strike and the tick at gauge 100 occur on the same clk, the strike SHALL take priority and damage SHALL be computed with G=100, giving 0.
REQ-020 DONE: atk_pass SHALL be 1, dmg_mon and atk_gage SHALL hold, and the block SHALL stay in DONE until atk_reset.
REQ-021 atk_pass SHALL be 0 in IDLE and RUN.
REQ-022 atk_reset=1 in any state SHALL, on the next clk, enter IDLE and set atk_gage=0, dmg_mon=0 and atk_pass=0.
REQ-023 atk_reset SHALL take priority over atk_start, strike and tick on the same clk.
REQ-024 |G-50| SHALL be computed without signed wrap: 50-G for G<50, else G-50.
REQ-025 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-026 reset low SHALL force: state=IDLE, atk_gage=0, dmg_mon=0, atk_pass=0, button-previous=0.
REQ-027 Reset assertion mid-RUN or in DONE SHALL abort the round and discard any result.
REQ-028 After reset is released, the first state-changing clk edge SHALL obey REQ-012.

Verification
REQ-029 Bench SHALL cover: reset low, atk_start=1 for 1 clk, 50 ticks, then button rising edge -> atk_gage=50, dmg_mon=40, atk_pass=1, atk_state=2.
REQ-030 Bench SHALL cover: start, 55 ticks, strike -> dmg_mon=35; start, 10 ticks, strike -> dmg_mon=0, atk_pass=1.
REQ-031 Bench SHALL cover: start, no press, 101 ticks -> atk_gage=100, dmg_mon=0, atk_pass=1; in DONE, extra ticks and strikes -> no change.
REQ-032 Bench SHALL cover: atk_button held high from before start, 20 ticks -> stays in RUN, no strike; release then press -> strike at gauge 20, dmg_mon=10.
REQ-033 Bench SHALL cover: in DONE, atk_reset=1 and atk_start=1 on the same clk -> IDLE, all outputs 0; next clk with atk_start=1 -> RUN.
REQ-034 Bench SHALL cover: reset pulsed low mid-RUN at gauge 30 -> outputs 0 immediately without a clk edge, state IDLE.

Source files
------------

// File: rtl/attack_gauge_if.sv
// ============================================================================
//  Module      : attack_gauge_if
//  Description : Signal bundle between the attack-round controller and its
//                environment.
//                Controls (master -> slave):
//                  tick        gauge-advance enable, one clk wide
//                  atk_start   level, requests an attack round
//                  atk_button  raw player strike button, level
//                  atk_reset   synchronous restart back to IDLE
//                Results (slave -> master):
//                  dmg_mon     damage dealt to the monster, 0..40
//                  atk_gage    current gauge position, 0..100
//                  atk_pass    high while a round result is valid
//                  atk_state   IDLE=0, RUN=1, DONE=2
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface attack_gauge_if;
  logic       tick;
  logic       atk_start;
  logic       atk_button;
  logic       atk_reset;
  logic [7:0] dmg_mon;
  logic [7:0] atk_gage;
  logic       atk_pass;
  logic [1:0] atk_state;

  // Environment side: drives the controls and observes the results.
  modport master (
    output tick,
    output atk_start,
    output atk_button,
    output atk_reset,
    input  dmg_mon,
    input  atk_gage,
    input  atk_pass,
    input  atk_state
  );

  // Controller side.
  modport slave (
    input  tick,
    input  atk_start,
    input  atk_button,
    input  atk_reset,
    output dmg_mon,
    output atk_gage,
    output atk_pass,
    output atk_state
  );
endinterface

`default_nettype wire

// File: rtl/attack_gauge.sv
// ============================================================================
//  Module      : attack_gauge
//  Description : Timing-gauge attack round. After a start request the gauge
//                climbs 0..100, one step per tick. A rising edge on the strike
//                button freezes the gauge and converts its distance from the
//                centre (50) into damage: 40 at dead centre, falling by one
//                per step, 0 at 40 or more steps away. Letting the gauge run
//                past 100 is a miss (damage 0). The result is held in DONE
//                until a synchronous restart.
//  Ports       : clk     system clock, rising edge
//                reset   asynchronous active-low reset
//                bus     attack_gauge_if.slave (controls in, results out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module attack_gauge (
  input  wire logic     clk,
  input  wire logic     reset,
  attack_gauge_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [7:0] c_GAGE_MAX = 8'd100;
  localparam logic [7:0] c_CENTER   = 8'd50;
  localparam logic [7:0] c_WINDOW   = 8'd40;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic [7:0] gage_q,  gage_d;
  logic [7:0] dmg_q,   dmg_d;
  logic       pass_q,  pass_d;
  logic       btn_q;

  // --------------------------------------------------------------------------
  // Strike detection and damage arithmetic
  // --------------------------------------------------------------------------
  logic       w_strike;
  logic       w_gage_full;
  logic [7:0] w_dist;
  logic [7:0] w_dmg;

  // Only a fresh press counts. btn_q follows the button in every state, so a
  // button already held when the round starts never looks like an edge.
  assign w_strike    = bus.atk_button & ~btn_q;
  assign w_gage_full = (gage_q == c_GAGE_MAX);

  // Distance from centre is formed by subtracting the smaller operand from
  // the larger one, so the unsigned result can never wrap.
  assign w_dist = (gage_q < c_CENTER) ? (c_CENTER - gage_q)
                                      : (gage_q - c_CENTER);

  assign w_dmg  = (w_dist < c_WINDOW) ? (c_WINDOW - w_dist) : 8'd0;

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // Restart wins over everything; within RUN a strike wins over the final
  // tick, so a press on the same edge as the overflow still scores (with G=100
  // that score is 0).
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.atk_reset) begin
      state_d = c_ST_IDLE;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (bus.atk_start) begin
            state_d = c_ST_RUN;
          end
        end
        c_ST_RUN: begin
          if (w_strike) begin
            state_d = c_ST_DONE;
          end else if (bus.tick && w_gage_full) begin
            state_d = c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          state_d = c_ST_DONE;
        end
        default: begin
          // Encoding 3 is unreachable in normal operation; recover to IDLE.
          state_d = c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 3: output / datapath next values
  // All outputs are taken from registers, so this block only prepares the
  // values they load on the next edge.
  // --------------------------------------------------------------------------
  always_comb begin
    gage_d = gage_q;
    dmg_d  = dmg_q;
    pass_d = (state_d == c_ST_DONE);

    if (bus.atk_reset) begin
      gage_d = 8'd0;
      dmg_d  = 8'd0;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          // Keeps the gauge parked at 0 so RUN always starts from the bottom.
          gage_d = 8'd0;
          dmg_d  = 8'd0;
        end
        c_ST_RUN: begin
          if (w_strike) begin
            // Gauge freezes at the value seen on the strike edge.
            dmg_d = w_dmg;
          end else if (bus.tick) begin
            if (w_gage_full) begin
              dmg_d = 8'd0;
            end else begin
              gage_d = gage_q + 8'd1;
            end
          end
        end
        c_ST_DONE: begin
          gage_d = gage_q;
          dmg_d  = dmg_q;
        end
        default: begin
          gage_d = 8'd0;
          dmg_d  = 8'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gage_q <= 8'd0;
      dmg_q  <= 8'd0;
      pass_q <= 1'b0;
      btn_q  <= 1'b0;
    end else begin
      gage_q <= gage_d;
      dmg_q  <= dmg_d;
      pass_q <= pass_d;
      btn_q  <= bus.atk_button;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  assign bus.dmg_mon   = dmg_q;
  assign bus.atk_gage  = gage_q;
  assign bus.atk_pass  = pass_q;
  assign bus.atk_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_attack_gauge.sv
// ============================================================================
//  Module      : tb_attack_gauge
//  Description : Self-checking bench for attack_gauge. Directed scenarios for
//                the documented rounds plus a randomized run checked against a
//                behavioural round model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_attack_gauge;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  attack_gauge_if bus ();

  attack_gauge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model: one round of the game, described by its rules.
  // --------------------------------------------------------------------------
  int m_state;   // 0 idle, 1 running, 2 done
  int m_gage;
  int m_dmg;
  int m_pass;
  int m_btn;

  function automatic int damage_of(input int g);
    int d;
    d = (g > 50) ? (g - 50) : (50 - g);
    return (d < 40) ? (40 - d) : 0;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_gage = 0; m_dmg = 0; m_pass = 0; m_btn = 0;
  endfunction

  function automatic void model_edge(input int t, input int s, input int b, input int r);
    bit pressed;
    pressed = (b != 0) && (m_btn == 0);
    if (r != 0) begin
      m_state = 0; m_gage = 0; m_dmg = 0; m_pass = 0;
    end else if (m_state == 0) begin
      if (s != 0) begin
        m_state = 1; m_gage = 0;
      end
    end else if (m_state == 1) begin
      if (pressed) begin
        m_dmg = damage_of(m_gage); m_state = 2; m_pass = 1;
      end else if (t != 0) begin
        if (m_gage == 100) begin
          m_dmg = 0; m_state = 2; m_pass = 1;
        end else begin
          m_gage = m_gage + 1;
        end
      end
    end
    m_btn = b;
  endfunction

  // Apply inputs, let one rising edge take them, then settle 1 time unit.
  task automatic drive(input int t, input int s, input int b, input int r);
    bus.tick       = (t != 0);
    bus.atk_start  = (s != 0);
    bus.atk_button = (b != 0);
    bus.atk_reset  = (r != 0);
    @(posedge clk);
    model_edge(t, s, b, r);
    #1;
  endtask

  // n ticks, each followed by a quiet cycle, button level held at b.
  task automatic ticks(input int n, input int b);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, b, 0);
      drive(0, 0, b, 0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    bus.tick = 1'b0; bus.atk_start = 1'b0; bus.atk_button = 1'b0; bus.atk_reset = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (bus.atk_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", bus.atk_state); end
    n_cmp++;
    if (bus.atk_gage !== 8'd0) begin n_fail++; $display("FAIL reset_gage got=%0d exp=0", bus.atk_gage); end
    n_cmp++;
    if (bus.dmg_mon !== 8'd0) begin n_fail++; $display("FAIL reset_dmg got=%0d exp=0", bus.dmg_mon); end
    n_cmp++;
    if (bus.atk_pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%0d exp=0", bus.atk_pass); end
    @(posedge clk); #1;
    reset = 1'b1;
    // First edge after release with start high must enter RUN.
    drive(0, 1, 0, 0);
    n_cmp++;
    if (bus.atk_state !== 2'd1 || bus.atk_gage !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_start state=%0d gage=%0d exp state=1 gage=0", bus.atk_state, bus.atk_gage);
    end
  endtask

  task automatic test_center_strike();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(50, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd50 || bus.atk_state !== 2'd1 || bus.atk_pass !== 1'b0) begin
      n_fail++; $display("FAIL center_pre gage=%0d state=%0d pass=%0d exp 50/1/0", bus.atk_gage, bus.atk_state, bus.atk_pass);
    end
    drive(0, 0, 1, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd50 || bus.dmg_mon !== 8'd40 || bus.atk_pass !== 1'b1 || bus.atk_state !== 2'd2) begin
      n_fail++; $display("FAIL center_strike gage=%0d dmg=%0d pass=%0d state=%0d exp 50/40/1/2",
                         bus.atk_gage, bus.dmg_mon, bus.atk_pass, bus.atk_state);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_off_center();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(55, 0);
    drive(0, 0, 1, 0);
    n_cmp++;
    if (bus.dmg_mon !== 8'd35 || bus.atk_gage !== 8'd55) begin
      n_fail++; $display("FAIL strike_55 dmg=%0d gage=%0d exp dmg=35 gage=55", bus.dmg_mon, bus.atk_gage);
    end
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(10, 0);
    drive(0, 0, 1, 0);
    n_cmp++;
    if (bus.dmg_mon !== 8'd0 || bus.atk_pass !== 1'b1 || bus.atk_gage !== 8'd10) begin
      n_fail++; $display("FAIL strike_10 dmg=%0d pass=%0d gage=%0d exp 0/1/10", bus.dmg_mon, bus.atk_pass, bus.atk_gage);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_miss();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(100, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd100 || bus.atk_state !== 2'd1) begin
      n_fail++; $display("FAIL miss_full gage=%0d state=%0d exp 100/1", bus.atk_gage, bus.atk_state);
    end
    ticks(1, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd100 || bus.dmg_mon !== 8'd0 || bus.atk_pass !== 1'b1 || bus.atk_state !== 2'd2) begin
      n_fail++; $display("FAIL miss_done gage=%0d dmg=%0d pass=%0d state=%0d exp 100/0/1/2",
                         bus.atk_gage, bus.dmg_mon, bus.atk_pass, bus.atk_state);
    end
    ticks(3, 0);
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 1, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd100 || bus.dmg_mon !== 8'd0 || bus.atk_pass !== 1'b1 || bus.atk_state !== 2'd2) begin
      n_fail++; $display("FAIL done_hold gage=%0d dmg=%0d pass=%0d state=%0d exp 100/0/1/2",
                         bus.atk_gage, bus.dmg_mon, bus.atk_pass, bus.atk_state);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_held_button();
    drive(0, 0, 1, 1);
    drive(0, 1, 1, 0);
    ticks(20, 1);
    n_cmp++;
    if (bus.atk_state !== 2'd1 || bus.atk_gage !== 8'd20 || bus.atk_pass !== 1'b0) begin
      n_fail++; $display("FAIL held_no_strike state=%0d gage=%0d pass=%0d exp 1/20/0", bus.atk_state, bus.atk_gage, bus.atk_pass);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    n_cmp++;
    if (bus.atk_state !== 2'd2 || bus.dmg_mon !== 8'd10 || bus.atk_gage !== 8'd20) begin
      n_fail++; $display("FAIL held_then_press state=%0d dmg=%0d gage=%0d exp 2/10/20", bus.atk_state, bus.dmg_mon, bus.atk_gage);
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_restart_priority();
    // Enter DONE via a quick strike first.
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(45, 0);
    drive(1, 0, 1, 0);   // strike and tick together: strike wins, G=45
    n_cmp++;
    if (bus.dmg_mon !== 8'd35 || bus.atk_gage !== 8'd45) begin
      n_fail++; $display("FAIL strike_with_tick dmg=%0d gage=%0d exp 35/45", bus.dmg_mon, bus.atk_gage);
    end
    drive(0, 1, 0, 1);
    n_cmp++;
    if (bus.atk_state !== 2'd0 || bus.atk_gage !== 8'd0 || bus.dmg_mon !== 8'd0 || bus.atk_pass !== 1'b0) begin
      n_fail++; $display("FAIL restart_prio state=%0d gage=%0d dmg=%0d pass=%0d exp all 0",
                         bus.atk_state, bus.atk_gage, bus.dmg_mon, bus.atk_pass);
    end
    drive(0, 1, 0, 0);
    n_cmp++;
    if (bus.atk_state !== 2'd1) begin
      n_fail++; $display("FAIL restart_then_start state=%0d exp 1", bus.atk_state);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    ticks(30, 0);
    n_cmp++;
    if (bus.atk_gage !== 8'd30) begin
      n_fail++; $display("FAIL async_pre gage=%0d exp 30", bus.atk_gage);
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (bus.atk_state !== 2'd0 || bus.atk_gage !== 8'd0 || bus.dmg_mon !== 8'd0 || bus.atk_pass !== 1'b0) begin
      n_fail++; $display("FAIL async_reset state=%0d gage=%0d dmg=%0d pass=%0d exp all 0",
                         bus.atk_state, bus.atk_gage, bus.dmg_mon, bus.atk_pass);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1, 0, 0, 0);
    n_cmp++;
    if (bus.atk_state !== 2'd0) begin
      n_fail++; $display("FAIL async_stays_idle state=%0d exp 0", bus.atk_state);
    end
  endtask

  task automatic test_random();
    int b;
    int t, s, r;
    b = 0;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 6000; i++) begin
      t = ($urandom_range(3) == 0) ? 1 : 0;
      s = ($urandom_range(7) == 0) ? 1 : 0;
      r = ($urandom_range(150) == 0) ? 1 : 0;
      if ($urandom_range(40) == 0) b = 1 - b;
      drive(t, s, b, r);
      n_cmp++;
      if (bus.atk_state !== 2'(m_state) || bus.atk_gage !== 8'(m_gage) ||
          bus.dmg_mon !== 8'(m_dmg) || bus.atk_pass !== 1'(m_pass)) begin
        n_fail++;
        $display("FAIL random cyc=%0d state=%0d/%0d gage=%0d/%0d dmg=%0d/%0d pass=%0d/%0d (got/exp)",
                 i, bus.atk_state, m_state, bus.atk_gage, m_gage, bus.dmg_mon, m_dmg, bus.atk_pass, m_pass);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_center_strike();
    test_off_center();
    test_miss();
    test_held_button();
    test_restart_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
